mat_mem_uart_tx: RTL and testbench

- Parametrised successor to the fixed result-matrix-to-UART transmitter.
- On a start request it walks a ROWS x COLS result memory in row-major order and splits each ELEM_W-bit element into bytes, MSB byte first.
- Each byte goes out as a standard 8N1 UART frame. An optional row delimiter byte is sent after each row.
- Sits between the matrix-result RAM (synchronous read, 1-cycle latency) and the board TX pin.

---
 rtl/mat_mem_uart_tx.sv | 228 ++++++++++++++++++++++
 tb/tb_mat_mem_uart_tx.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_mem_uart_tx.sv
// ---------------------------------------------------------------------------
// mat_mem_uart_tx
//
// Dumps a ROWS x COLS result matrix held in a synchronous-read RAM onto a
// UART TX pin. A rising edge on read_R_mat walks the memory in row-major
// order. Each element is split into bytes, most significant byte first, and
// each byte is sent as an 8N1 frame. An optional delimiter byte can follow
// every row.
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-low reset
//   read_R_mat  start request; a rising edge starts one full matrix dump
//   mem_addr    result memory read address (registered)
//   mem_rdata   result memory data, valid one cycle after mem_addr
//   tx_data     UART serial line, idle high (registered)
//   tx_status   high while a dump is in progress (registered)
//   done        one-cycle pulse after the final stop bit (registered)
// ---------------------------------------------------------------------------
module mat_mem_uart_tx #(
    parameter int          ROWS         = 2,
    parameter int          COLS         = 2,
    parameter int          ELEM_W       = 16,
    parameter int          ADDR_W       = 4,
    parameter int          CLKS_PER_BIT = 10416,
    parameter int          ROW_DELIM_EN = 0,
    parameter logic [7:0]  DELIM_BYTE   = 8'h0A
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_R_mat,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [ELEM_W-1:0] mem_rdata,
    output logic              tx_data,
    output logic              tx_status,
    output logic              done
);

    localparam int NB       = (ELEM_W + 7) / 8;
    localparam int BUF_W    = NB * 8;
    localparam int CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIDX_W   = (NB > 1) ? $clog2(NB) : 1;
    localparam int COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int NUM_ELEM = ROWS * COLS;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIDX_W-1:0] BYTE_TOP  = BIDX_W'(NB - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] LAST_ELEM = ADDR_W'(NUM_ELEM - 1);

    // Bit positions inside one frame: 0 = start, 1..8 = data, 9 = stop.
    localparam logic [3:0] STOP_POS = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_LOAD   = 3'd3,
        S_FRAME  = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               read_R_mat_q;
    logic [ADDR_W-1:0]  elem_q, elem_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [BIDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [3:0]         bit_idx_q, bit_idx_d;
    logic [BUF_W-1:0]   shift_buf_q, shift_buf_d;
    logic               delim_q, delim_d;
    logic               tx_data_q, tx_data_d;
    logic               tx_status_q, tx_status_d;
    logic               done_q, done_d;

    logic               start_s;
    logic               col_last_s;
    logic [7:0]         frame_byte_s;

    // Pick byte number idx (0 = least significant) out of the element buffer.
    function automatic logic [7:0] sel_byte(input logic [BUF_W-1:0] b,
                                            input logic [BIDX_W-1:0] idx);
        logic [BUF_W-1:0] s;
        s = b >> {idx, 3'b000};
        return s[7:0];
    endfunction

    // Line level for a given frame position: start low, data LSB first, stop high.
    function automatic logic line_bit(input logic [3:0] pos, input logic [7:0] b);
        logic v;
        case (pos)
            4'd0:    v = 1'b0;
            4'd1:    v = b[0];
            4'd2:    v = b[1];
            4'd3:    v = b[2];
            4'd4:    v = b[3];
            4'd5:    v = b[4];
            4'd6:    v = b[5];
            4'd7:    v = b[6];
            4'd8:    v = b[7];
            default: v = 1'b1;
        endcase
        return v;
    endfunction

    assign start_s    = read_R_mat & ~read_R_mat_q;
    assign col_last_s = (col_q == COL_LAST);

    // State register plus all datapath and output flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            read_R_mat_q <= 1'b0;
            elem_q       <= {ADDR_W{1'b0}};
            col_q        <= {COL_W{1'b0}};
            byte_idx_q   <= {BIDX_W{1'b0}};
            bit_cnt_q    <= {CNT_W{1'b0}};
            bit_idx_q    <= 4'd0;
            shift_buf_q  <= {BUF_W{1'b0}};
            delim_q      <= 1'b0;
            tx_data_q    <= 1'b1;
            tx_status_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            read_R_mat_q <= read_R_mat;
            elem_q       <= elem_d;
            col_q        <= col_d;
            byte_idx_q   <= byte_idx_d;
            bit_cnt_q    <= bit_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_buf_q  <= shift_buf_d;
            delim_q      <= delim_d;
            tx_data_q    <= tx_data_d;
            tx_status_q  <= tx_status_d;
            done_q       <= done_d;
        end
    end

    // Next-state and datapath update. The next-byte / delimiter / next-element
    // decision is taken in the last cycle of the stop bit so frames of one
    // element follow each other without an idle gap.
    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        col_d       = col_q;
        byte_idx_d  = byte_idx_q;
        bit_cnt_d   = bit_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_buf_d = shift_buf_q;
        delim_d     = delim_q;
        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    state_d = S_FETCH;
                    elem_d  = {ADDR_W{1'b0}};
                    col_d   = {COL_W{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                shift_buf_d = BUF_W'(mem_rdata);
                byte_idx_d  = BYTE_TOP;
                delim_d     = 1'b0;
                bit_cnt_d   = {CNT_W{1'b0}};
                bit_idx_d   = 4'd0;
                state_d     = S_FRAME;
            end
            S_FRAME: begin
                if (bit_cnt_q != CNT_LAST) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end else begin
                    bit_cnt_d = {CNT_W{1'b0}};
                    if (bit_idx_q != STOP_POS) begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end else begin
                        bit_idx_d = 4'd0;
                        if (!delim_q && (byte_idx_q != {BIDX_W{1'b0}})) begin
                            byte_idx_d = byte_idx_q - BIDX_W'(1);
                        end else if (!delim_q && (ROW_DELIM_EN != 0) && col_last_s) begin
                            delim_d = 1'b1;
                        end else if (elem_q != LAST_ELEM) begin
                            elem_d  = elem_q + ADDR_W'(1);
                            col_d   = col_last_s ? {COL_W{1'b0}} : (col_q + COL_W'(1));
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_FINISH;
                        end
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the registered line tracks the
    // frame state cycle-for-cycle.
    always_comb begin
        frame_byte_s = 8'h00;
        tx_data_d    = 1'b1;
        tx_status_d  = (state_d != S_IDLE) && (state_d != S_FINISH);
        done_d       = (state_d == S_FINISH);
        if (state_d == S_FRAME) begin
            frame_byte_s = delim_d ? DELIM_BYTE : sel_byte(shift_buf_d, byte_idx_d);
            tx_data_d    = line_bit(bit_idx_d, frame_byte_s);
        end else begin
            tx_data_d    = 1'b1;
        end
    end

    assign mem_addr  = elem_q;
    assign tx_data   = tx_data_q;
    assign tx_status = tx_status_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mat_mem_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_mat_mem_uart_tx
//
// Three instances of mat_mem_uart_tx with CLKS_PER_BIT=4:
//   A: 2x2, 16-bit elements, no delimiter
//   B: 2x2, 16-bit elements, delimiter 0x0A after each row
//   C: 3x1, 8-bit elements, 2-bit address
// Expected bytes are built from the bench memory contents and queued when a
// dump is requested; per-instance UART decoders pop and compare each frame.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mat_mem_uart_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_a, read_b, read_c;
    logic [3:0]  addr_a, addr_b;
    logic [1:0]  addr_c;
    logic [15:0] rdata_a, rdata_b;
    logic [7:0]  rdata_c;
    logic        tx_a, tx_b, tx_c;
    logic        st_a, st_b, st_c;
    logic        done_a, done_b, done_c;

    logic [15:0] mem_ab [16];
    logic [7:0]  mem_c  [4];

    logic [7:0]  q_a[$];
    logic [7:0]  q_b[$];
    logic [7:0]  q_c[$];

    int n_checks = 0;
    int n_err    = 0;
    int frames   [3];
    int stat_cyc [3];
    int done_cyc [3];

    always #5 clk = ~clk;

    mat_mem_uart_tx #(.ROWS(2), .COLS(2), .ELEM_W(16), .ADDR_W(4),
                      .CLKS_PER_BIT(CPB), .ROW_DELIM_EN(0), .DELIM_BYTE(8'h0A)) u_a (
        .clk(clk), .rst(rst), .read_R_mat(read_a), .mem_addr(addr_a),
        .mem_rdata(rdata_a), .tx_data(tx_a), .tx_status(st_a), .done(done_a));

    mat_mem_uart_tx #(.ROWS(2), .COLS(2), .ELEM_W(16), .ADDR_W(4),
                      .CLKS_PER_BIT(CPB), .ROW_DELIM_EN(1), .DELIM_BYTE(8'h0A)) u_b (
        .clk(clk), .rst(rst), .read_R_mat(read_b), .mem_addr(addr_b),
        .mem_rdata(rdata_b), .tx_data(tx_b), .tx_status(st_b), .done(done_b));

    mat_mem_uart_tx #(.ROWS(3), .COLS(1), .ELEM_W(8), .ADDR_W(2),
                      .CLKS_PER_BIT(CPB), .ROW_DELIM_EN(0), .DELIM_BYTE(8'h0A)) u_c (
        .clk(clk), .rst(rst), .read_R_mat(read_c), .mem_addr(addr_c),
        .mem_rdata(rdata_c), .tx_data(tx_c), .tx_status(st_c), .done(done_c));

    // Synchronous-read memories, one cycle latency.
    always @(posedge clk) begin
        rdata_a <= mem_ab[addr_a];
        rdata_b <= mem_ab[addr_b];
        rdata_c <= mem_c[addr_c];
    end

    // Busy-cycle and done-cycle counters per instance.
    always @(negedge clk) begin
        if (st_a)   stat_cyc[0]++;
        if (st_b)   stat_cyc[1]++;
        if (st_c)   stat_cyc[2]++;
        if (done_a) done_cyc[0]++;
        if (done_b) done_cyc[1]++;
        if (done_c) done_cyc[2]++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic tx_of(input int w);
        case (w)
            0:       return tx_a;
            1:       return tx_b;
            default: return tx_c;
        endcase
    endfunction

    function automatic logic done_of(input int w);
        case (w)
            0:       return done_a;
            1:       return done_b;
            default: return done_c;
        endcase
    endfunction

    function automatic logic st_of(input int w);
        case (w)
            0:       return st_a;
            1:       return st_b;
            default: return st_c;
        endcase
    endfunction

    function automatic int qsize(input int w);
        case (w)
            0:       return q_a.size();
            1:       return q_b.size();
            default: return q_c.size();
        endcase
    endfunction

    task automatic push_byte(input int w, input logic [7:0] b);
        case (w)
            0:       q_a.push_back(b);
            1:       q_b.push_back(b);
            default: q_c.push_back(b);
        endcase
    endtask

    task automatic pop_byte(input int w, output logic [7:0] b);
        case (w)
            0:       b = q_a.pop_front();
            1:       b = q_b.pop_front();
            default: b = q_c.pop_front();
        endcase
    endtask

    task automatic set_read(input int w, input logic v);
        case (w)
            0:       read_a = v;
            1:       read_b = v;
            default: read_c = v;
        endcase
    endtask

    // Reference model: row-major walk, MSB byte first, optional row delimiter.
    task automatic push_exp(input int w);
        int rows, cols, nb;
        bit de;
        logic [31:0] v;
        rows = (w == 2) ? 3 : 2;
        cols = (w == 2) ? 1 : 2;
        nb   = (w == 2) ? 1 : 2;
        de   = (w == 1);
        for (int e = 0; e < rows * cols; e++) begin
            v = (w == 2) ? {24'd0, mem_c[e]} : {16'd0, mem_ab[e]};
            for (int b = nb - 1; b >= 0; b--) push_byte(w, v[8*b +: 8]);
            if (de && ((e % cols) == cols - 1)) push_byte(w, 8'h0A);
        end
    endtask

    // Decode one frame whose start bit was just seen; a frame cut by reset is dropped.
    task automatic rx_frame(input int w);
        logic [7:0] b;
        logic [7:0] e;
        logic       sb, pb, ok;
        ok = rst;
        repeat (CPB / 2) @(negedge clk);
        ok = ok & rst;
        sb = tx_of(w);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            ok   = ok & rst;
            b[i] = tx_of(w);
        end
        repeat (CPB) @(negedge clk);
        ok = ok & rst;
        pb = tx_of(w);
        if (ok) begin
            check($sformatf("start_bit_%0d", w), 64'(sb), 64'd0);
            check($sformatf("stop_bit_%0d", w), 64'(pb), 64'd1);
            if (qsize(w) == 0) begin
                check($sformatf("unexpected_frame_%0d", w), 64'(b), 64'hFFFF);
            end else begin
                pop_byte(w, e);
                check($sformatf("byte_%0d", w), 64'(b), 64'(e));
            end
            frames[w]++;
        end
    endtask

    always begin
        @(negedge clk);
        if (rst === 1'b1 && tx_a === 1'b0) rx_frame(0);
    end
    always begin
        @(negedge clk);
        if (rst === 1'b1 && tx_b === 1'b0) rx_frame(1);
    end
    always begin
        @(negedge clk);
        if (rst === 1'b1 && tx_c === 1'b0) rx_frame(2);
    end

    task automatic wait_done(input int w, input int budget);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (done_of(w)) seen = 1'b1;
        end
        check($sformatf("done_seen_%0d", w), 64'(seen), 64'd1);
    endtask

    // One complete dump with start latency, busy time, done count and
    // optionally the exact line waveform of the first frame.
    task automatic run_dump(input int w, input int nfr, input int stat_exp,
                            input bit cap, input logic [7:0] first_byte);
        int f0, s0, d0, lat;
        logic st1;
        logic [39:0] obs, expl;
        f0 = frames[w]; s0 = stat_cyc[w]; d0 = done_cyc[w];
        push_exp(w);
        @(negedge clk);
        set_read(w, 1'b1);
        lat = -1;
        st1 = 1'b0;
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) st1 = st_of(w);
            if (tx_of(w) == 1'b0) lat = n;
        end
        check($sformatf("status_after_start_%0d", w), 64'(st1), 64'd1);
        check($sformatf("start_latency_%0d", w), 64'(lat), 64'd4);
        if (cap) begin
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                obs[k] = tx_of(w);
                case (k / CPB)
                    0:       expl[k] = 1'b0;
                    9:       expl[k] = 1'b1;
                    default: expl[k] = first_byte[k / CPB - 1];
                endcase
            end
            check($sformatf("line_pattern_%0d", w), 64'(obs), 64'(expl));
        end
        wait_done(w, 3000);
        repeat (5) @(negedge clk);
        set_read(w, 1'b0);
        check($sformatf("frames_%0d", w), 64'(frames[w] - f0), 64'(nfr));
        check($sformatf("busy_cycles_%0d", w), 64'(stat_cyc[w] - s0), 64'(stat_exp));
        check($sformatf("done_pulses_%0d", w), 64'(done_cyc[w] - d0), 64'd1);
        check($sformatf("queue_empty_%0d", w), 64'(qsize(w)), 64'd0);
    endtask

    initial begin
        int f0, s0, d0;
        rst = 1'b0; read_a = 1'b0; read_b = 1'b0; read_c = 1'b0;
        for (int i = 0; i < 16; i++) mem_ab[i] = 16'h0000;
        mem_ab[0] = 16'h1234; mem_ab[1] = 16'hABCD; mem_ab[2] = 16'h0001; mem_ab[3] = 16'hFF00;
        mem_c[0] = 8'h55; mem_c[1] = 8'h00; mem_c[2] = 8'hFF; mem_c[3] = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_tx_a",     64'(tx_a),   64'd1);
        check("rst_status_a", 64'(st_a),   64'd0);
        check("rst_done_a",   64'(done_a), 64'd0);
        check("rst_addr_a",   64'(addr_a), 64'd0);
        check("rst_tx_c",     64'(tx_c),   64'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Basic dumps: 8 frames + 4 gaps, 10 frames with delimiters, 8-bit elements.
        run_dump(0, 8, 8 * 10 * CPB + 4 * 3, 1'b0, 8'h00);
        run_dump(1, 10, 10 * 10 * CPB + 4 * 3, 1'b0, 8'h00);
        run_dump(2, 3, 3 * 10 * CPB + 3 * 3, 1'b1, 8'h55);

        // Extra edges mid-dump and a held-high request give exactly one dump.
        f0 = frames[0]; d0 = done_cyc[0];
        push_exp(0);
        @(negedge clk); read_a = 1'b1;
        repeat (60)  @(negedge clk); read_a = 1'b0;
        repeat (20)  @(negedge clk); read_a = 1'b1;
        repeat (100) @(negedge clk); read_a = 1'b0;
        repeat (5)   @(negedge clk); read_a = 1'b1;
        wait_done(0, 3000);
        repeat (400) @(negedge clk);
        check("held_frames", 64'(frames[0] - f0), 64'd8);
        check("held_done",   64'(done_cyc[0] - d0), 64'd1);
        check("held_queue",  64'(qsize(0)), 64'd0);
        read_a = 1'b0;
        repeat (2) @(negedge clk);
        run_dump(0, 8, 8 * 10 * CPB + 4 * 3, 1'b0, 8'h00);

        // Reset during the third frame.
        f0 = frames[0];
        push_exp(0);
        @(negedge clk); read_a = 1'b1;
        repeat (10) @(negedge clk); read_a = 1'b0;
        repeat (90) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_tx_now",     64'(tx_a), 64'd1);
        check("rst_mid_status_now", 64'(st_a), 64'd0);
        repeat (5) @(negedge clk);
        check("rst_mid_tx_hold",     64'(tx_a),   64'd1);
        check("rst_mid_status_hold", 64'(st_a),   64'd0);
        check("rst_mid_done_hold",   64'(done_a), 64'd0);
        rst = 1'b1;
        check("rst_mid_frames_before", 64'(frames[0] - f0), 64'd2);
        q_a.delete();
        f0 = frames[0]; s0 = stat_cyc[0]; d0 = done_cyc[0];
        repeat (400) @(negedge clk);
        check("post_rst_no_frames", 64'(frames[0] - f0), 64'd0);
        check("post_rst_no_busy",   64'(stat_cyc[0] - s0), 64'd0);
        check("post_rst_no_done",   64'(done_cyc[0] - d0), 64'd0);
        run_dump(0, 8, 8 * 10 * CPB + 4 * 3, 1'b0, 8'h00);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
